// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_pkg
//  Description : Shared types and sizing helpers for the successive-
//                approximation value finder.
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

  // Search controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ceil(log2(n)) but never less than one bit, so a register always exists
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of the per-probe wait counter: max(1, clog2(PROBE_WAIT+1))
  function automatic int cnt_width(input int probe_wait);
    return clog2_min1(probe_wait + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_value_finder.sv
`default_nettype none
// ============================================================================
//  Module      : sar_value_finder
//  Description : Recovers a hidden WIDTH-bit value through a single-bit
//                "secret > probe" comparator, one result bit per probe,
//                MSB first. Each probe is held PROBE_WAIT+1 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_value_finder
  import sar_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PROBE_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_greater,
  output logic [WIDTH-1:0] o_probe,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_value
);

  localparam int             c_BW   = clog2_min1(WIDTH);
  localparam int             c_CW   = cnt_width(PROBE_WAIT);
  localparam logic [c_CW-1:0] c_PW   = c_CW'(PROBE_WAIT);
  localparam logic [c_BW-1:0] c_MSB  = c_BW'(WIDTH - 1);

  state_t            r_state;
  logic [c_BW-1:0]   r_bit;
  logic [WIDTH-1:0]  r_acc;
  logic [c_CW-1:0]   r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic [WIDTH-1:0]  r_value;

  logic [WIDTH-1:0]  w_trial;
  logic [WIDTH-1:0]  w_acc_next;

  // Candidate with the current bit set; probing trial-1 turns the strict
  // "secret > probe" answer into "secret >= trial" and keeps the all-ones
  // value off the comparator input.
  always_comb begin
    w_trial    = r_acc | (WIDTH'(1) << r_bit);
    w_acc_next = i_greater ? w_trial : r_acc;
    o_probe    = (r_state == PROBE) ? (w_trial - WIDTH'(1)) : '0;
  end

  // Search controller with registered status/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_value <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= PROBE;
            r_bit   <= c_MSB;
            r_acc   <= '0;
            r_cnt   <= c_PW;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        PROBE: begin
          if (i_abort) begin
            // Cancel wins over a sample falling in the same cycle
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CW'(1);
          end else begin
            r_acc <= w_acc_next;
            if (r_bit == '0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
              r_value <= w_acc_next;
            end else begin
              r_bit <= r_bit - c_BW'(1);
              r_cnt <= c_PW;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_valid = r_valid;
  assign o_value = r_value;

endmodule
`default_nettype wire
